dual_issue_scoreboard: RTL and testbench

Issue-stage scheduler for the dual-issue SPU. It decides each cycle whether the instruction pair at decode issues as zero, one or two instructions. It tracks per-register result-availability countdowns that match the even/odd forwarding network latencies, and it enforces the structural, RAW and WAW rules between the two slots. It sits between decode and register fetch, and it gates which operand addresses reach the forwarding/register-fetch stage.

---
 rtl/dual_issue_scoreboard.sv | 143 ++++++++++++++
 tb/tb_dual_issue_scoreboard.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scoreboard.sv
// Dual-issue issue-stage scoreboard.
// Grants zero, one or two instructions per cycle from the decode pair. Grants are
// combinational. A per-register countdown models when each in-flight result becomes
// forwardable. Slot 1 never issues without slot 0, so the pair always stays in program order.
module dual_issue_scoreboard #(
    parameter int unsigned REG_ADDR_WIDTH = 7,
    parameter int unsigned LAT_WIDTH      = 4,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    // Slot 0 (older instruction)
    input  logic                      i0_valid,
    input  logic                      i0_pipe,
    input  logic [REG_ADDR_WIDTH-1:0] i0_ra,
    input  logic [REG_ADDR_WIDTH-1:0] i0_rb,
    input  logic [REG_ADDR_WIDTH-1:0] i0_rc,
    input  logic [2:0]                i0_use,
    input  logic [REG_ADDR_WIDTH-1:0] i0_rt,
    input  logic                      i0_wr,
    input  logic [LAT_WIDTH-1:0]      i0_lat,
    // Slot 1 (younger instruction)
    input  logic                      i1_valid,
    input  logic                      i1_pipe,
    input  logic [REG_ADDR_WIDTH-1:0] i1_ra,
    input  logic [REG_ADDR_WIDTH-1:0] i1_rb,
    input  logic [REG_ADDR_WIDTH-1:0] i1_rc,
    input  logic [2:0]                i1_use,
    input  logic [REG_ADDR_WIDTH-1:0] i1_rt,
    input  logic                      i1_wr,
    input  logic [LAT_WIDTH-1:0]      i1_lat,
    // Grants and status
    output logic                      issue0,
    output logic                      issue1,
    output logic                      dual_issue,
    output logic                      stall,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
    typedef logic [LAT_WIDTH-1:0]      lat_t;
    typedef logic [CNT_WIDTH-1:0]      cnt_t;

    // Remaining cycles until each register's pending result is forwardable.
    lat_t busy_q [NumRegs];
    lat_t busy_d [NumRegs];
    cnt_t stall_count_q;
    cnt_t stall_count_d;

    logic [NumRegs-1:0] reg_busy;

    logic i0_blocked;
    logic i1_blocked;
    logic i1_raw;
    logic i1_waw;
    logic i1_struct;
    logic ld0;
    logic ld1;
    lat_t ld0_val;
    lat_t ld1_val;

    // Collapse each countdown to a single busy flag.
    always_comb begin
        reg_busy = '0;
        for (int unsigned r = 0; r < NumRegs; r++) begin
            reg_busy[r] = (busy_q[r] != '0);
        end
    end

    // Source blocking, intra-pair hazards and the grant decision.
    always_comb begin
        // use bits are ordered {ra, rb, rc}
        i0_blocked = (i0_use[2] & reg_busy[i0_ra])
                   | (i0_use[1] & reg_busy[i0_rb])
                   | (i0_use[0] & reg_busy[i0_rc]);
        i1_blocked = (i1_use[2] & reg_busy[i1_ra])
                   | (i1_use[1] & reg_busy[i1_rb])
                   | (i1_use[0] & reg_busy[i1_rc]);

        // Slot 0's result is never forwardable in the same cycle, so any in-pair consumer waits.
        i1_raw = i0_wr & ((i1_use[2] & (i1_ra == i0_rt))
                        | (i1_use[1] & (i1_rb == i0_rt))
                        | (i1_use[0] & (i1_rc == i0_rt)));
        i1_waw    = i0_wr & i1_wr & (i0_rt == i1_rt);
        i1_struct = (i1_pipe == i0_pipe);

        issue0 = i0_valid & ~flush & ~reset & ~i0_blocked;
        issue1 = issue0 & i1_valid & ~i1_blocked & ~i1_struct & ~i1_raw & ~i1_waw;
        dual_issue = issue0 & issue1;
        stall = i0_valid & ~issue0 & ~flush & ~reset;
    end

    // Countdown load values; a zero latency behaves like a one-cycle latency.
    always_comb begin
        ld0 = issue0 & i0_wr;
        ld1 = issue1 & i1_wr;
        ld0_val = (i0_lat == '0) ? '0 : i0_lat - lat_t'(1);
        ld1_val = (i1_lat == '0) ? '0 : i1_lat - lat_t'(1);
    end

    // Per-register next state: a fresh load overrides the running countdown.
    always_comb begin
        for (int unsigned r = 0; r < NumRegs; r++) begin
            busy_d[r] = busy_q[r];
            if (ld0 && (i0_rt == addr_t'(r))) begin
                busy_d[r] = ld0_val;
            end else if (ld1 && (i1_rt == addr_t'(r))) begin
                busy_d[r] = ld1_val;
            end else if (busy_q[r] != '0) begin
                busy_d[r] = busy_q[r] - lat_t'(1);
            end
        end
    end

    // Saturating stall counter next state.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + cnt_t'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                busy_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                busy_q[r] <= busy_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Bench for dual_issue_scoreboard: directed steps, then random pairs.
// Reference model keeps an absolute "ready cycle" per register instead of countdowns.
module tb_dual_issue_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, flush;
    logic       i0_valid, i0_pipe, i0_wr, i1_valid, i1_pipe, i1_wr;
    logic [6:0] i0_ra, i0_rb, i0_rc, i0_rt, i1_ra, i1_rb, i1_rc, i1_rt;
    logic [2:0] i0_use, i1_use;
    logic [3:0] i0_lat, i1_lat;

    logic        issue0, issue1, dual_issue, stall;
    logic [15:0] stall_count;
    logic        issue0_s, issue1_s, dual_issue_s, stall_s;
    logic [3:0]  stall_count_s;

    dual_issue_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush),
        .i0_valid(i0_valid), .i0_pipe(i0_pipe), .i0_ra(i0_ra), .i0_rb(i0_rb), .i0_rc(i0_rc),
        .i0_use(i0_use), .i0_rt(i0_rt), .i0_wr(i0_wr), .i0_lat(i0_lat),
        .i1_valid(i1_valid), .i1_pipe(i1_pipe), .i1_ra(i1_ra), .i1_rb(i1_rb), .i1_rc(i1_rc),
        .i1_use(i1_use), .i1_rt(i1_rt), .i1_wr(i1_wr), .i1_lat(i1_lat),
        .issue0(issue0), .issue1(issue1), .dual_issue(dual_issue), .stall(stall),
        .stall_count(stall_count)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    dual_issue_scoreboard #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset(reset), .flush(flush),
        .i0_valid(i0_valid), .i0_pipe(i0_pipe), .i0_ra(i0_ra), .i0_rb(i0_rb), .i0_rc(i0_rc),
        .i0_use(i0_use), .i0_rt(i0_rt), .i0_wr(i0_wr), .i0_lat(i0_lat),
        .i1_valid(i1_valid), .i1_pipe(i1_pipe), .i1_ra(i1_ra), .i1_rb(i1_rb), .i1_rc(i1_rc),
        .i1_use(i1_use), .i1_rt(i1_rt), .i1_wr(i1_wr), .i1_lat(i1_lat),
        .issue0(issue0_s), .issue1(issue1_s), .dual_issue(dual_issue_s), .stall(stall_s),
        .stall_count(stall_count_s)
    );

    // Reference model state
    longint ready [128];
    longint cyc = 0;
    int     cnt_big = 0;
    int     cnt_small = 0;
    bit     cnt_known = 0;
    bit     e_i0, e_i1, e_st;
    int     n_cmp = 0;
    int     n_err = 0;

    function automatic bit is_free(input logic [6:0] r);
        return cyc >= ready[r];
    endfunction

    function automatic bit src_ok(input logic [2:0] u, input logic [6:0] a, input logic [6:0] b,
                                  input logic [6:0] c);
        return (!u[2] || is_free(a)) && (!u[1] || is_free(b)) && (!u[0] || is_free(c));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drv0(input bit v, input bit p, input int ra, input int rb, input int rc,
                        input logic [2:0] u, input int rt, input bit w, input int lat);
        i0_valid = v; i0_pipe = p; i0_ra = 7'(ra); i0_rb = 7'(rb); i0_rc = 7'(rc);
        i0_use = u; i0_rt = 7'(rt); i0_wr = w; i0_lat = 4'(lat);
    endtask

    task automatic drv1(input bit v, input bit p, input int ra, input int rb, input int rc,
                        input logic [2:0] u, input int rt, input bit w, input int lat);
        i1_valid = v; i1_pipe = p; i1_ra = 7'(ra); i1_rb = 7'(rb); i1_rc = 7'(rc);
        i1_use = u; i1_rt = 7'(rt); i1_wr = w; i1_lat = 4'(lat);
    endtask

    task automatic idle();
        drv0(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        drv1(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        flush = 0;
    endtask

    // Settle inputs, derive expectations from the issue rules, compare.
    task automatic step_begin(input string tag);
        bit raw, waw;
        #1;
        e_i0 = i0_valid && !flush && !reset && src_ok(i0_use, i0_ra, i0_rb, i0_rc);
        raw = i0_wr && ((i1_use[2] && i1_ra == i0_rt) || (i1_use[1] && i1_rb == i0_rt) ||
                        (i1_use[0] && i1_rc == i0_rt));
        waw = i0_wr && i1_wr && (i0_rt == i1_rt);
        e_i1 = e_i0 && i1_valid && src_ok(i1_use, i1_ra, i1_rb, i1_rc) &&
               (i1_pipe != i0_pipe) && !raw && !waw;
        e_st = i0_valid && !e_i0 && !flush && !reset;
        chk({tag, ".issue0"}, 32'(issue0), 32'(e_i0));
        chk({tag, ".issue1"}, 32'(issue1), 32'(e_i1));
        chk({tag, ".dual"}, 32'(dual_issue), 32'(e_i0 && e_i1));
        chk({tag, ".stall"}, 32'(stall), 32'(e_st));
        chk({tag, ".issue0_s"}, 32'(issue0_s), 32'(e_i0));
        if (cnt_known) begin
            chk({tag, ".count"}, 32'(stall_count), cnt_big);
            chk({tag, ".count_s"}, 32'(stall_count_s), cnt_small);
        end
    endtask

    // Commit this cycle into the model and move to the next cycle.
    task automatic step_end();
        if (reset) begin
            foreach (ready[r]) ready[r] = 0;
            cnt_big = 0;
            cnt_small = 0;
            cnt_known = 1;
        end else begin
            if (e_i0 && i0_wr) ready[i0_rt] = cyc + ((i0_lat == 0) ? 1 : longint'(i0_lat));
            if (e_i1 && i1_wr) ready[i1_rt] = cyc + ((i1_lat == 0) ? 1 : longint'(i1_lat));
            if (e_st) begin
                if (cnt_big < 65535) cnt_big++;
                if (cnt_small < 15) cnt_small++;
            end
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(input string tag);
        step_begin(tag);
        step_end();
    endtask

    initial begin
        foreach (ready[r]) ready[r] = 0;
        idle();
        reset = 1;
        drv0(1, 0, 5, 0, 0, 3'b100, 0, 0, 1);
        @(negedge clk);

        // Reset held for two cycles with a valid slot 0
        for (int i = 0; i < 2; i++) begin
            step_begin("rst");
            chk("rst_issue0", 32'(issue0), 0);
            chk("rst_stall", 32'(stall), 0);
            step_end();
        end
        reset = 0;
        step_begin("rel");
        chk("rel_count", 32'(stall_count), 0);
        chk("rel_issue0", 32'(issue0), 1);
        step_end();

        // Latency countdown on r10, lat 6
        drv0(1, 0, 0, 0, 0, 3'b000, 10, 1, 6);
        tick("lat_load");
        drv0(1, 0, 10, 0, 0, 3'b100, 0, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            step_begin("lat_wait");
            chk("lat_stall", 32'(stall), 1);
            step_end();
        end
        step_begin("lat_go");
        chk("lat_issue0", 32'(issue0), 1);
        chk("lat_count", 32'(stall_count), 5);
        step_end();

        // Dual issue, then structural conflict
        drv0(1, 0, 0, 0, 0, 3'b000, 3, 1, 2);
        drv1(1, 1, 4, 0, 0, 3'b100, 7, 1, 1);
        step_begin("dual");
        chk("dual_ok", 32'(dual_issue), 1);
        step_end();
        drv1(1, 0, 4, 0, 0, 3'b100, 7, 1, 1);
        step_begin("struct");
        chk("struct_i0", 32'(issue0), 1);
        chk("struct_i1", 32'(issue1), 0);
        step_end();
        idle();
        tick("gap");
        tick("gap");

        // Intra-pair RAW / WAW / unused source
        drv0(1, 0, 0, 0, 0, 3'b000, 3, 1, 1);
        drv1(1, 1, 3, 0, 0, 3'b100, 9, 1, 1);
        step_begin("raw");
        chk("raw_i1", 32'(issue1), 0);
        step_end();
        drv1(1, 1, 20, 0, 0, 3'b100, 3, 1, 1);
        step_begin("waw");
        chk("waw_i1", 32'(issue1), 0);
        step_end();
        drv1(1, 1, 21, 3, 0, 3'b100, 9, 1, 1);
        step_begin("nouse");
        chk("nouse_i1", 32'(issue1), 1);
        step_end();

        // Overwrite r8 (lat 7, then lat 2 two cycles later), then flush
        idle();
        drv0(1, 0, 0, 0, 0, 3'b000, 8, 1, 7);
        tick("ow_load1");
        idle();
        tick("ow_gap");
        drv0(1, 0, 0, 0, 0, 3'b000, 8, 1, 2);
        tick("ow_load2");
        drv0(1, 0, 8, 0, 0, 3'b100, 0, 0, 1);
        step_begin("ow_wait");
        chk("ow_wait_i0", 32'(issue0), 0);
        step_end();
        step_begin("ow_go");
        chk("ow_go_i0", 32'(issue0), 1);
        step_end();
        flush = 1;
        step_begin("flush");
        chk("flush_i0", 32'(issue0), 0);
        chk("flush_stall", 32'(stall), 0);
        chk("flush_cnt0", 32'(stall_count), 6);
        step_end();
        idle();
        step_begin("post_flush");
        chk("flush_cnt1", 32'(stall_count), 6);
        step_end();

        // Saturation: 20 blocked cycles after a fresh reset
        reset = 1;
        tick("sat_rst");
        reset = 0;
        drv0(1, 0, 0, 0, 0, 3'b000, 40, 1, 15);
        tick("sat_load");
        drv0(1, 0, 40, 0, 0, 3'b100, 0, 0, 1);
        for (int i = 0; i < 14; i++) tick("sat_a");
        drv0(1, 0, 0, 0, 0, 3'b000, 40, 1, 15);
        tick("sat_reload");
        drv0(1, 0, 40, 0, 0, 3'b100, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick("sat_b");
        idle();
        step_begin("sat_chk");
        chk("sat_small", 32'(stall_count_s), 15);
        chk("sat_big", 32'(stall_count), 20);
        step_end();

        // Reset mid-countdown frees every register
        drv0(1, 0, 0, 0, 0, 3'b000, 40, 1, 15);
        tick("mid_load");
        reset = 1;
        idle();
        tick("mid_rst");
        reset = 0;
        drv0(1, 0, 40, 0, 0, 3'b100, 0, 0, 1);
        step_begin("mid_go");
        chk("mid_issue0", 32'(issue0), 1);
        step_end();

        // Random pairs over a small register window to provoke hazards
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(63) == 0);
            flush = ($urandom_range(15) == 0);
            drv0($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(7),
                 $urandom_range(7), $urandom_range(7), 3'($urandom_range(7)),
                 $urandom_range(7), 1'($urandom_range(1)), $urandom_range(7));
            drv1($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(7),
                 $urandom_range(7), $urandom_range(7), 3'($urandom_range(7)),
                 $urandom_range(7), 1'($urandom_range(1)), $urandom_range(7));
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
